// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: entry layout, drain FSM states,
// request direction encoding and a word-address helper.
package store_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_WEN_W  = 4;

  // Request direction value driven on *_rw while a write is in flight
  localparam logic SB_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    SB_IDLE    = 2'b00,
    SB_CACHE   = 2'b01,
    SB_UNCACHE = 2'b10
  } sb_state_t;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_WEN_W-1:0]  wen;
    logic                 uncache;
    logic                 valid;
  } sb_entry_t;

  // Word address (byte offset dropped) used for load hazard comparison
  function automatic logic [29:0] sb_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_sb_addr_match.sv
// sb_addr_match: parallel word-address compare of a load against every valid
// store-buffer entry, plus selection of the youngest matching entry.
module sb_addr_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [DEPTH-1:0][29:0] entry_word,
  input  logic [DEPTH-1:0]       entry_valid,
  input  logic [PTR_W-1:0]       head,
  input  logic [29:0]            ld_word,
  output logic                   any_match,
  output logic [PTR_W-1:0]       young_idx
);

  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] idx;

  // Per-entry compare against the load word address
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = entry_valid[i] & (entry_word[i] == ld_word);
    end
  end

  assign any_match = |match;

  // Walk from oldest (head) to youngest; the last hit seen is the youngest
  always_comb begin
    young_idx = head;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (match[idx]) young_idx = idx;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: committed-store FIFO that drains stores in program order to
// the cached (store_mem_*) or uncached (store_uncache_*) request port, holding
// each request until its data_ok. Reports full/empty and load hazards.
// Optional store-to-load forwarding of full-word entries: STORE_BUF_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flus,
  input  logic        push_en,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_data,
  input  logic [3:0]  push_wen,
  input  logic        push_uncache,
  output logic        sb_full,
  output logic        sb_empty,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
`ifdef STORE_BUF_FWD_EN
  output logic        ld_fwd_hit,
  output logic [31:0] ld_fwd_data,
`endif
  output logic        store_mem_en,
  output logic        store_mem_rw,
  output logic [31:0] store_mem_addr,
  output logic [31:0] store_mem_data,
  output logic [3:0]  store_mem_rwen,
  input  logic        store_mem_data_ok,
  output logic        store_uncache_en,
  output logic        store_uncache_rw,
  output logic [31:0] store_uncache_addr,
  output logic [31:0] store_uncache_data,
  output logic [3:0]  store_uncache_rwen,
  input  logic        store_uncache_data_ok
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_n;
  sb_state_t        state;
  sb_state_t        state_n;
  sb_entry_t        head_e;
  logic             push_ok;
  logic             pop;

  assign head_e   = entries[head];
  assign sb_full  = (count == FULL_CNT);
  assign sb_empty = (count == '0) && (state == SB_IDLE);
  assign push_ok  = push_en & ~flus & ~sb_full;

  // Occupancy bookkeeping for push/pop in the same cycle
  always_comb begin
    count_n = count;
    unique case ({push_ok, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // Entry storage and FIFO pointers; push never targets the in-flight head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (push_ok) begin
        entries[tail] <= '{addr: push_addr, data: push_data, wen: push_wen,
                           uncache: push_uncache, valid: 1'b1};
        tail          <= tail + 1'b1;
      end
      count <= count_n;
    end
  end

  // Drain state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SB_IDLE;
    else        state <= state_n;
  end

  // Drain next-state, request outputs and pop
  always_comb begin
    state_n            = state;
    pop                = 1'b0;
    store_mem_en       = 1'b0;
    store_mem_rw       = 1'b0;
    store_mem_addr     = '0;
    store_mem_data     = '0;
    store_mem_rwen     = '0;
    store_uncache_en   = 1'b0;
    store_uncache_rw   = 1'b0;
    store_uncache_addr = '0;
    store_uncache_data = '0;
    store_uncache_rwen = '0;
    unique case (state)
      SB_IDLE: begin
        if (count != '0) state_n = head_e.uncache ? SB_UNCACHE : SB_CACHE;
      end
      SB_CACHE: begin
        store_mem_en   = 1'b1;
        store_mem_rw   = SB_RW_WRITE;
        store_mem_addr = head_e.addr;
        store_mem_data = head_e.data;
        store_mem_rwen = head_e.wen;
        if (store_mem_data_ok) begin
          pop     = 1'b1;
          state_n = SB_IDLE;
        end
      end
      SB_UNCACHE: begin
        store_uncache_en   = 1'b1;
        store_uncache_rw   = SB_RW_WRITE;
        store_uncache_addr = head_e.addr;
        store_uncache_data = head_e.data;
        store_uncache_rwen = head_e.wen;
        if (store_uncache_data_ok) begin
          pop     = 1'b1;
          state_n = SB_IDLE;
        end
      end
      default: state_n = SB_IDLE;
    endcase
  end

  logic [DEPTH-1:0][29:0] match_word;
  logic [DEPTH-1:0]       match_valid;
  logic                   any_match;
  logic [PTR_W-1:0]       young_idx;
  logic                   unused_ld_lo;

  assign unused_ld_lo = ^ld_addr[1:0];

  // Flatten entry addresses/valids for the comparator
  always_comb begin
    match_word  = '0;
    match_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_word[i]  = sb_word(entries[i].addr);
      match_valid[i] = entries[i].valid;
    end
  end

  sb_addr_match #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_match (
    .entry_word  (match_word),
    .entry_valid (match_valid),
    .head        (head),
    .ld_word     (sb_word(ld_addr)),
    .any_match   (any_match),
    .young_idx   (young_idx)
  );

`ifdef STORE_BUF_FWD_EN
  logic young_full;

  // Forward only when the youngest match covers all four byte lanes
  always_comb begin
    young_full  = any_match && (entries[young_idx].wen == '1);
    ld_fwd_hit  = young_full;
    ld_fwd_data = young_full ? entries[young_idx].data : '0;
    ld_hazard   = any_match & ~young_full;
  end
`else
  logic unused_young_idx;

  assign unused_young_idx = ^young_idx;
  assign ld_hazard        = any_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table-driven pushes and load probes,
// hand-written multi-cycle sequences, and a scoreboard that checks every
// drained request in program order. Define STORE_BUF_FWD_EN to cover forwarding.
module tb_store_buffer;

`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flus;
  logic        push_en;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_wen;
  logic        push_uncache;
  logic        sb_full;
  logic        sb_empty;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        store_mem_en, store_mem_rw;
  logic [31:0] store_mem_addr, store_mem_data;
  logic [3:0]  store_mem_rwen;
  logic        store_mem_data_ok;
  logic        store_uncache_en, store_uncache_rw;
  logic [31:0] store_uncache_addr, store_uncache_data;
  logic [3:0]  store_uncache_rwen;
  logic        store_uncache_data_ok;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .flus                  (flus),
    .push_en               (push_en),
    .push_addr             (push_addr),
    .push_data             (push_data),
    .push_wen              (push_wen),
    .push_uncache          (push_uncache),
    .sb_full               (sb_full),
    .sb_empty              (sb_empty),
    .ld_addr               (ld_addr),
    .ld_hazard             (ld_hazard),
`ifdef STORE_BUF_FWD_EN
    .ld_fwd_hit            (ld_fwd_hit),
    .ld_fwd_data           (ld_fwd_data),
`endif
    .store_mem_en          (store_mem_en),
    .store_mem_rw          (store_mem_rw),
    .store_mem_addr        (store_mem_addr),
    .store_mem_data        (store_mem_data),
    .store_mem_rwen        (store_mem_rwen),
    .store_mem_data_ok     (store_mem_data_ok),
    .store_uncache_en      (store_uncache_en),
    .store_uncache_rw      (store_uncache_rw),
    .store_uncache_addr    (store_uncache_addr),
    .store_uncache_data    (store_uncache_data),
    .store_uncache_rwen    (store_uncache_rwen),
    .store_uncache_data_ok (store_uncache_data_ok)
  );

`ifndef STORE_BUF_FWD_EN
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wen;
    bit          unc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wen;
    bit          unc;
    bit          exp_full;
  } vec_t;

  typedef struct {
    logic [31:0] ld;
    bit          haz;
    bit          hit;
    logic [31:0] fdata;
  } probe_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   ack_on   = 1'b0;
  int   ack_delay = 1;
  bit   acked_prev = 1'b0;
  int   en_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Drive one push for a cycle; called at a negedge, returns at the next one
  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] w, input bit u, input bit fl,
                            input bit track);
    exp_t e;
    bit   acc;
    acc          = !sb_full && !fl;
    push_en      = 1'b1;
    flus         = fl;
    push_addr    = a;
    push_data    = d;
    push_wen     = w;
    push_uncache = u;
    if (acc && track) begin
      e.addr = a; e.data = d; e.wen = w; e.unc = u;
      sb_q.push_back(e);
    end
    @(negedge clk);
    push_en = 1'b0;
    flus    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb_empty && sb_q.size() == 0) done = 1'b1;
    end
    check({name, "_empty"}, 32'(sb_empty), 32'd1);
    check({name, "_queue"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Memory-side responder and scoreboard: acks after ack_delay request
  // cycles and checks each completed request against the expected order
  initial begin
    exp_t e;
    store_mem_data_ok     = 1'b0;
    store_uncache_data_ok = 1'b0;
    forever begin
      @(negedge clk);
      store_mem_data_ok     = 1'b0;
      store_uncache_data_ok = 1'b0;
      if (acked_prev)
        check("idle_gap", 32'(store_mem_en | store_uncache_en), 32'd0);
      acked_prev = 1'b0;
      if (!ack_on || !(store_mem_en || store_uncache_en)) begin
        en_cyc = 0;
      end else begin
        en_cyc++;
        if (en_cyc >= ack_delay) begin
          check("overlap", 32'(store_mem_en & store_uncache_en), 32'd0);
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_request: got request mem=%0b unc=%0b, expected none",
                     store_mem_en, store_uncache_en);
          end else begin
            e = sb_q.pop_front();
            check("req_uncache", 32'(store_uncache_en), 32'(e.unc));
            if (store_uncache_en) begin
              check("unc_addr", store_uncache_addr, e.addr);
              check("unc_data", store_uncache_data, e.data);
              check("unc_wen", 32'(store_uncache_rwen), 32'(e.wen));
              check("unc_rw", 32'(store_uncache_rw), 32'd1);
            end else begin
              check("mem_addr", store_mem_addr, e.addr);
              check("mem_data", store_mem_data, e.data);
              check("mem_wen", 32'(store_mem_rwen), 32'(e.wen));
              check("mem_rw", 32'(store_mem_rw), 32'd1);
            end
          end
          if (store_uncache_en) store_uncache_data_ok = 1'b1;
          else                  store_mem_data_ok     = 1'b1;
          en_cyc     = 0;
          acked_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   fill [4];
    probe_t pr1 [4];
    probe_t pr2 [2];
    int     n;

    fill[0] = '{32'h8000_0100, 32'h0000_0001, 4'hF, 1'b0, 1'b0};
    fill[1] = '{32'h8000_0104, 32'h0000_0002, 4'h3, 1'b0, 1'b0};
    fill[2] = '{32'hBFD0_0008, 32'h0000_0003, 4'h1, 1'b1, 1'b0};
    fill[3] = '{32'h8000_0108, 32'h0000_0004, 4'hC, 1'b0, 1'b1};

    pr1[0] = '{32'h8000_0042, 1'b1, 1'b0, 32'h0};
    pr1[1] = '{32'h8000_0044, 1'b0, 1'b0, 32'h0};
    pr1[2] = '{32'h8000_0203, !FWD, FWD, FWD ? 32'h1111_2222 : 32'h0};
    pr1[3] = '{32'h8000_0240, 1'b0, 1'b0, 32'h0};
    pr2[0] = '{32'h8000_0050, !FWD, FWD, FWD ? 32'h1234_5678 : 32'h0};
    pr2[1] = '{32'h8000_0041, !FWD, FWD, FWD ? 32'hAAAA_5555 : 32'h0};

    reset = 1'b0; flus = 1'b0; push_en = 1'b0; push_addr = '0;
    push_data = '0; push_wen = '0; push_uncache = 1'b0; ld_addr = 32'hFFFF_FFF0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_full", 32'(sb_full), 32'd0);
    check("rst_mem_en", 32'(store_mem_en), 32'd0);
    check("rst_unc_en", 32'(store_uncache_en), 32'd0);
    check("rst_hazard", 32'(ld_hazard), 32'd0);
    reset = 1'b1;

    // A flushed push never enters the buffer
    push_store(32'h8000_0010, 32'h5555_5555, 4'hF, 1'b0, 1'b1, 1'b1);
    check("flush_empty", 32'(sb_empty), 32'd1);

    // Single cached store, data_ok on the third request cycle
    ack_delay = 3; ack_on = 1'b1;
    push_store(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b1);
    check("t1_not_empty", 32'(sb_empty), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (store_mem_en) begin
        n++;
        check("t1_hold_addr", store_mem_addr, 32'h8000_0010);
        check("t1_hold_data", store_mem_data, 32'hDEAD_BEEF);
      end else if (n > 0) begin
        break;
      end
    end
    check("t1_en_cycles", 32'(n), 32'd3);
    check("t1_empty_after", 32'(sb_empty), 32'd1);

    // Uncached then cached: uncached issues first, one idle cycle between
    ack_delay = 2;
    push_store(32'hBFD0_0000, 32'h0000_00A5, 4'h1, 1'b1, 1'b0, 1'b1);
    push_store(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (store_mem_en || store_uncache_en) break;
      @(negedge clk);
    end
    check("t2_first_unc", 32'(store_uncache_en), 32'd1);
    check("t2_first_mem", 32'(store_mem_en), 32'd0);
    check("t2_first_addr", store_uncache_addr, 32'hBFD0_0000);
    wait_drain("t2");

    // Fill to full with no acks, drop a fifth push, then release one entry
    ack_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_store(fill[i].addr, fill[i].data, fill[i].wen, fill[i].unc, 1'b0, 1'b1);
      check("fill_full", 32'(sb_full), 32'(fill[i].exp_full));
    end
    push_store(32'h8000_0FF0, 32'hBAD0_BAD0, 4'hF, 1'b0, 1'b0, 1'b1);
    check("drop_full", 32'(sb_full), 32'd1);
    @(posedge clk);
    ack_delay = 1; ack_on = 1'b1;
    @(negedge clk);
    check("full_at_ack", 32'(sb_full), 32'd1);
    @(negedge clk);
    check("full_cleared", 32'(sb_full), 32'd0);
    wait_drain("t3");

    // Load hazard probes with entries held pending
    ack_on = 1'b0;
    push_store(32'h8000_0040, 32'h0000_BEEF, 4'h3, 1'b0, 1'b0, 1'b1);
    push_store(32'h8000_0200, 32'h1111_2222, 4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ld_addr = pr1[i].ld;
      #2;
      check("haz1", 32'(ld_hazard), 32'(pr1[i].haz));
`ifdef STORE_BUF_FWD_EN
      check("fwd1_hit", 32'(ld_fwd_hit), 32'(pr1[i].hit));
      check("fwd1_data", ld_fwd_data, pr1[i].fdata);
`endif
      @(negedge clk);
    end
    push_store(32'h8000_0050, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b1);
    push_store(32'h8000_0040, 32'hAAAA_5555, 4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      ld_addr = pr2[i].ld;
      #2;
      check("haz2", 32'(ld_hazard), 32'(pr2[i].haz));
`ifdef STORE_BUF_FWD_EN
      check("fwd2_hit", 32'(ld_fwd_hit), 32'(pr2[i].hit));
      check("fwd2_data", ld_fwd_data, pr2[i].fdata);
`endif
      @(negedge clk);
    end
    ld_addr = 32'hFFFF_FFF0;
    ack_delay = 1; ack_on = 1'b1;
    wait_drain("t4");

    // Reset asserted while a cached write is in flight with 3 entries
    ack_on = 1'b0;
    push_store(32'h8000_0300, 32'h0000_0011, 4'hF, 1'b0, 1'b0, 1'b0);
    push_store(32'h8000_0304, 32'h0000_0022, 4'hF, 1'b0, 1'b0, 1'b0);
    push_store(32'h8000_0308, 32'h0000_0033, 4'hF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (store_mem_en) break;
      @(negedge clk);
    end
    check("t6_inflight", 32'(store_mem_en), 32'd1);
    ld_addr = 32'h8000_0304;
    #2 reset = 1'b0;
    #1;
    check("t6_mem_en", 32'(store_mem_en), 32'd0);
    check("t6_empty", 32'(sb_empty), 32'd1);
    check("t6_full", 32'(sb_full), 32'd0);
    check("t6_hazard", 32'(ld_hazard), 32'd0);
    check("t6_addr", store_mem_addr, 32'h0);
    @(negedge clk);
    check("t6_empty_hold", 32'(sb_empty), 32'd1);
    reset = 1'b1;
    ld_addr = 32'hFFFF_FFF0;
    ack_delay = 2; ack_on = 1'b1;
    push_store(32'h8000_0400, 32'h0BAD_CAFE, 4'h6, 1'b0, 1'b0, 1'b1);
    push_store(32'hBFD0_0400, 32'h0000_7777, 4'hF, 1'b1, 1'b0, 1'b1);
    wait_drain("t6");

    // Random mix with flushes, back-pressure and varying ack latency
    for (int i = 0; i < 40; i++) begin
      ack_delay = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0)
        push_store(32'h8000_1000 + (32'($urandom_range(0, 255)) << 2), $urandom,
                   4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), 1'b1);
      else
        @(negedge clk);
    end
    wait_drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
